// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencing controller for a restoring shift/subtract divider. The
//   datapath holds A (partial remainder), Q (dividend/quotient) and M
//   (divisor); this block only issues the strobes that step it through WIDTH
//   iterations and hands the result to the consumer with a valid/ready pair.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   division request, taken only while in_ready=1
//   divisor_zero in   divisor == 0, sampled together with start
//   a_msb        in   sign of A after the subtract (used in CHECK only)
//   out_ready    in   consumer takes the result (used in DONE only)
//   in_ready     out  idle, a new start will be accepted
//   ld           out  load Q and M, clear A
//   lshift       out  shift A:Q left one bit
//   a_sub        out  A <= A - M
//   a_restore    out  A <= A + M (negative trial remainder)
//   q0_wr        out  write Q[0]
//   q0_val       out  value for Q[0]
//   busy         out  run in progress (LOAD..CHECK)
//   out_valid    out  quotient/remainder valid
//   div_by_zero  out  result invalid, divisor was zero (qualified by out_valid)
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start, in_ready=1
// LOAD   | operands loaded into the datapath, iteration counter cleared
// SHIFT  | A:Q shifted left one bit
// SUB    | trial subtract A - M
// CHECK  | quotient bit written, A restored when the trial went negative
// DONE   | result presented until out_ready
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic divisor_zero,
  input  logic a_msb,
  input  logic out_ready,
  output logic in_ready,
  output logic ld,
  output logic lshift,
  output logic a_sub,
  output logic a_restore,
  output logic q0_wr,
  output logic q0_val,
  output logic busy,
  output logic out_valid,
  output logic div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_dz;

  logic            r_in_ready;
  logic            r_ld;
  logic            r_lshift;
  logic            r_a_sub;
  logic            r_q0_wr;
  logic            r_busy;
  logic            r_out_valid;
  logic            r_div_by_zero;

  state_t          w_next;
  logic            w_dz_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = r_dz ? S_DONE : S_SHIFT;
      S_SHIFT: w_next = S_SUB;
      S_SUB:   w_next = S_CHECK;
      S_CHECK: w_next = (r_cnt == LAST_ITER) ? S_DONE : S_SHIFT;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The zero-divisor flag is only captured on the accepting edge; it keeps
  // its value through the run and is only exposed while in DONE.
  assign w_dz_next = (r_state == S_IDLE && start) ? divisor_zero : r_dz;

  // Outputs are decoded from the next state so that they are registered yet
  // still line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      r_in_ready    <= 1'b1;
      r_ld          <= 1'b0;
      r_lshift      <= 1'b0;
      r_a_sub       <= 1'b0;
      r_q0_wr       <= 1'b0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dz    <= w_dz_next;

      if (r_state == S_LOAD) begin
        r_cnt <= '0;
      end else if (r_state == S_CHECK && r_cnt != LAST_ITER) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_in_ready    <= (w_next == S_IDLE);
      r_ld          <= (w_next == S_LOAD);
      r_lshift      <= (w_next == S_SHIFT);
      r_a_sub       <= (w_next == S_SUB);
      r_q0_wr       <= (w_next == S_CHECK);
      r_busy        <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_out_valid   <= (w_next == S_DONE);
      r_div_by_zero <= (w_next == S_DONE) && w_dz_next;
    end
  end

  assign in_ready    = r_in_ready;
  assign ld          = r_ld;
  assign lshift      = r_lshift;
  assign a_sub       = r_a_sub;
  assign q0_wr       = r_q0_wr;
  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign div_by_zero = r_div_by_zero;

  // Restore decision needs the sign of the subtract result from this very
  // cycle, so it is gated combinationally by the registered CHECK strobe.
  assign a_restore   = r_q0_wr & a_msb;
  assign q0_val      = r_q0_wr & ~a_msb;

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand width and iteration count (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; accepted only when in_ready=1.
REQ-005 SHALL have port divisor_zero  input  1  divisor operand equals 0, valid in the cycle start is sampled.
REQ-006 SHALL have port a_msb  input  1  sign bit of partial remainder A after subtract, from the datapath.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have port in_ready  output  1  high exactly in IDLE.
REQ-009 SHALL have port ld  output  1  load dividend into the Q left-shift register, load the divisor register, clear A.
REQ-010 SHALL have port lshift  output  1  shift A:Q left one bit; drives lshift of both shift registers.
REQ-011 SHALL have port a_sub  output  1  A <= A - M.
REQ-012 SHALL have port a_restore  output  1  A <= A + M.
REQ-013 SHALL have port q0_wr  output  1  write Q[0].
REQ-014 SHALL have port q0_val  output  1  value written to Q[0].
REQ-015 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-016 SHALL have port out_valid  output  1  quotient/remainder in datapath valid; high exactly in DONE.
REQ-017 SHALL have port div_by_zero  output  1  result invalid due to zero divisor; valid while out_valid=1.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, LOAD, SHIFT, SUB, CHECK, DONE; all outputs except q0_wr/q0_val/a_restore decode from state only.
REQ-019 IDLE -> LOAD when start=1; otherwise stay in IDLE; dz flag <= divisor_zero on the accepting edge.
REQ-020 LOAD: ld=1, iteration counter cleared to 0; next state DONE when dz flag=1, else SHIFT.
REQ-021 SHIFT: lshift=1 for exactly one cycle; next state SUB.
REQ-022 SUB: a_sub=1 for exactly one cycle; next state CHECK.
REQ-023 CHECK: q0_wr=1; a_msb=1 -> a_restore=1, q0_val=0; a_msb=0 -> a_restore=0, q0_val=1.
REQ-024 CHECK: counter==WIDTH-1 -> DONE; otherwise counter increments by 1 and next state is SHIFT.
REQ-025 Counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap during a run.
REQ-026 DONE: out_valid=1, held until out_ready=1; DONE -> IDLE on the edge where out_ready=1.
REQ-027 div_by_zero SHALL equal the dz flag while in DONE and SHALL be 0 in all other states.
REQ-028 Latency: start accepted at edge 0 -> LOAD in cycle 1, SHIFT/SUB/CHECK in cycles 2..3*WIDTH+1, DONE from cycle 3*WIDTH+2 (cycle 50 for WIDTH=16).
REQ-029 Zero-divisor latency: LOAD in cycle 1, DONE in cycle 2; no lshift/a_sub/q0_wr pulses.
REQ-030 start SHALL be ignored in every state except IDLE, including DONE while out_ready=1.
REQ-031 At most one of ld, lshift, a_sub, a_restore SHALL be high in any cycle.
REQ-032 out_ready SHALL be ignored in every state except DONE.
REQ-033 a_msb SHALL be ignored in every state except CHECK.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE, counter=0, and dz flag=0 regardless of state or other inputs.
REQ-035 While in IDLE after reset: in_ready=1; all other outputs 0.
REQ-036 Reset asserted mid-run SHALL abort the run without any further datapath strobes from the next cycle onward.
REQ-037 reset SHALL take priority over start when both are high at the same edge.

Verification
REQ-038 Reset then start=1 (WIDTH=16, divisor_zero=0), a_msb=0 throughout -> 16 lshift, 16 a_sub, 16 q0_wr pulses with q0_val=1, no a_restore; out_valid first in cycle 50.
REQ-039 Same run, a_msb=1 throughout -> 16 a_restore pulses in CHECK, q0_val=0 each time; out_valid in cycle 50, div_by_zero=0.
REQ-040 start with divisor_zero=1 -> ld in cycle 1; out_valid=1 and div_by_zero=1 in cycle 2; zero lshift pulses.
REQ-041 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1; out_ready=1 -> IDLE next cycle; start pulses during busy and DONE -> ignored.
REQ-042 reset pulse in the SUB state of iteration 7 -> IDLE next cycle, all strobes 0; new start -> full 50-cycle run with counter restarting at 0.
